md_io_regs: RTL and testbench

MD_IO_REGS -- requirements
Module: md_io_regs

---
 rtl/md_io_regs.sv | 155 +++++++++++++++
 tb/tb_md_io_regs.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_io_regs.sv
// md_io_regs: host-side I/O register file for two controller ports plus an EXT
// port, with serial-port storage and an optional TH-pin level-2 interrupt.
// Latency: writes land at the strobe edge; dout is registered one edge after a read strobe.
// Backpressure: none, every cs strobe completes in a single cycle.
// Ports: i_clk/i_reset (async active-high); i_cs/i_we/i_addr/i_din/o_dout host access;
//        i_export/i_pal/i_ndisk version straps; i_portN_out sampled pin levels;
//        o_portN_in/o_portN_dir drive the pad stage; o_hl/i_hl_ack interrupt.
// Build option: define MD_IO_TH_INT_EN to enable the TH falling-edge interrupt;
//        without it o_hl is tied low and CTRLn[7] is plain storage.
module md_io_regs (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cs,
  input  logic       i_we,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  input  logic       i_export,
  input  logic       i_pal,
  input  logic       i_ndisk,
  input  logic [6:0] i_port1_out,
  input  logic [6:0] i_port2_out,
  output logic [6:0] o_port1_in,
  output logic [6:0] o_port2_in,
  output logic [6:0] o_port1_dir,
  output logic [6:0] o_port2_dir,
  output logic       o_hl,
  input  logic       i_hl_ack
);

  logic [7:0] r_data   [3];
  logic [7:0] r_ctrl   [3];
  logic [7:0] r_txdata [3];
  logic [4:0] r_sctrl  [3];   // only bits 7..3 are stored
  logic [6:0] r_smp1;
  logic [6:0] r_smp2;
  logic [7:0] r_dout;
  logic [7:0] w_rd_dat;
  logic       w_wr;
  logic       w_rd;

  assign w_wr = i_cs & i_we;
  assign w_rd = i_cs & ~i_we;

  // Pins configured as outputs read back the stored level, inputs read the
  // sampled pad level; bit 7 is always the stored value.
  function automatic logic [7:0] f_data_rd(input logic [7:0] d, input logic [7:0] c,
                                           input logic [6:0] pins);
    return {d[7], (c[6:0] & d[6:0]) | (~c[6:0] & pins)};
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_smp1 <= 7'h7F;
      r_smp2 <= 7'h7F;
    end else begin
      r_smp1 <= i_port1_out;
      r_smp2 <= i_port2_out;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 3; i++) begin
        r_data[i]   <= 8'h7F;
        r_ctrl[i]   <= 8'h00;
        r_txdata[i] <= 8'hFF;
        r_sctrl[i]  <= 5'h00;
      end
    end else if (w_wr) begin
      case (i_addr)
        4'd1:    r_data[0]   <= i_din;
        4'd2:    r_data[1]   <= i_din;
        4'd3:    r_data[2]   <= i_din;
        4'd4:    r_ctrl[0]   <= i_din;
        4'd5:    r_ctrl[1]   <= i_din;
        4'd6:    r_ctrl[2]   <= i_din;
        4'd7:    r_txdata[0] <= i_din;
        4'd9:    r_sctrl[0]  <= i_din[7:3];
        4'd10:   r_txdata[1] <= i_din;
        4'd12:   r_sctrl[1]  <= i_din[7:3];
        4'd13:   r_txdata[2] <= i_din;
        4'd15:   r_sctrl[2]  <= i_din[7:3];
        default: ;  // VERSION and RXDATAn are read-only
      endcase
    end
  end

  always_comb begin
    w_rd_dat = 8'h00;
    case (i_addr)
      4'd0:  w_rd_dat = {i_export, i_pal, i_ndisk, 5'b0};
      4'd1:  w_rd_dat = f_data_rd(r_data[0], r_ctrl[0], r_smp1);
      4'd2:  w_rd_dat = f_data_rd(r_data[1], r_ctrl[1], r_smp2);
      4'd3:  w_rd_dat = f_data_rd(r_data[2], r_ctrl[2], 7'h7F);  // EXT pins float high
      4'd4:  w_rd_dat = r_ctrl[0];
      4'd5:  w_rd_dat = r_ctrl[1];
      4'd6:  w_rd_dat = r_ctrl[2];
      4'd7:  w_rd_dat = r_txdata[0];
      4'd9:  w_rd_dat = {r_sctrl[0], 3'b000};
      4'd10: w_rd_dat = r_txdata[1];
      4'd12: w_rd_dat = {r_sctrl[1], 3'b000};
      4'd13: w_rd_dat = r_txdata[2];
      4'd15: w_rd_dat = {r_sctrl[2], 3'b000};
      default: w_rd_dat = 8'h00;  // RXDATAn
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dout <= 8'h00;
    end else if (w_rd) begin
      r_dout <= w_rd_dat;
    end
  end

  assign o_dout      = r_dout;
  assign o_port1_in  = r_data[0][6:0];
  assign o_port2_in  = r_data[1][6:0];
  assign o_port1_dir = r_ctrl[0][6:0];
  assign o_port2_dir = r_ctrl[1][6:0];

`ifdef MD_IO_TH_INT_EN
  logic r_th1_prev;
  logic r_th2_prev;
  logic r_hl;
  logic w_set;
  logic w_clr;

  // A port is armed when TH interrupts are enabled and TH is an input pin.
  assign w_set = (r_ctrl[0][7] & ~r_ctrl[0][6] & r_th1_prev & ~r_smp1[6]) |
                 (r_ctrl[1][7] & ~r_ctrl[1][6] & r_th2_prev & ~r_smp2[6]);
  assign w_clr = i_hl_ack | (w_wr & ((i_addr == 4'd4) | (i_addr == 4'd5)) & ~i_din[7]);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_th1_prev <= 1'b1;
      r_th2_prev <= 1'b1;
      r_hl       <= 1'b0;
    end else begin
      r_th1_prev <= r_smp1[6];
      r_th2_prev <= r_smp2[6];
      if (w_set)      r_hl <= 1'b1;  // a fresh edge beats a simultaneous clear
      else if (w_clr) r_hl <= 1'b0;
    end
  end

  assign o_hl = r_hl;
`else
  logic w_unused_ack;
  assign w_unused_ack = i_hl_ack;
  assign o_hl = 1'b0;
`endif

endmodule

// File: tb/tb_md_io_regs.sv
module tb_md_io_regs;

`ifdef MD_IO_TH_INT_EN
  localparam bit TH = 1'b1;
`else
  localparam bit TH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, cs, we, x_export, pal, ndisk, hl_ack;
  logic [3:0] addr;
  logic [7:0] din;
  logic [6:0] p1o, p2o;
  logic [7:0] dout;
  logic [6:0] p1i, p2i, p1d, p2d;
  logic       hl;

  always #5 clk = ~clk;

  md_io_regs dut (
    .i_clk(clk), .i_reset(reset), .i_cs(cs), .i_we(we), .i_addr(addr), .i_din(din),
    .o_dout(dout), .i_export(x_export), .i_pal(pal), .i_ndisk(ndisk),
    .i_port1_out(p1o), .i_port2_out(p2o), .o_port1_in(p1i), .o_port2_in(p2i),
    .o_port1_dir(p1d), .o_port2_dir(p2d), .o_hl(hl), .i_hl_ack(hl_ack)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: register contents by name, pin history as seen by the bus side.
  logic [7:0] m_data [1:3];
  logic [7:0] m_ctrl [1:3];
  logic [7:0] m_tx   [1:3];
  logic [7:0] m_sc   [1:3];
  logic [6:0] m_pins [1:2];   // pin levels visible to reads this cycle
  logic       m_th_last [1:2]; // TH level visible one cycle earlier
  logic [7:0] m_dout;
  logic       m_hl;

  task automatic m_reset();
    for (int n = 1; n <= 3; n++) begin
      m_data[n] = 8'h7F; m_ctrl[n] = 8'h00; m_tx[n] = 8'hFF; m_sc[n] = 8'h00;
    end
    for (int n = 1; n <= 2; n++) begin
      m_pins[n] = 7'h7F; m_th_last[n] = 1'b1;
    end
    m_dout = 8'h00;
    m_hl   = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] a);
    logic [7:0] r;
    logic [6:0] pins;
    int n, kind;
    r = 8'h00;
    if (a == 0) begin
      r = {x_export, pal, ndisk, 5'b0};
    end else if (a <= 3) begin
      n = a;
      pins = (n == 3) ? 7'h7F : m_pins[n];
      for (int i = 0; i < 7; i++) r[i] = m_ctrl[n][i] ? m_data[n][i] : pins[i];
      r[7] = m_data[n][7];
    end else if (a <= 6) begin
      r = m_ctrl[a - 3];
    end else begin
      n = (a - 7) / 3 + 1;
      kind = (a - 7) % 3;
      r = (kind == 0) ? m_tx[n] : (kind == 1) ? 8'h00 : m_sc[n];
    end
    return r;
  endfunction

  task automatic m_step();
    bit set, clr;
    int n, kind;
    set = 0;
    if (cs && !we) m_dout = m_read(addr);
    if (TH) begin
      for (int p = 1; p <= 2; p++)
        if (m_ctrl[p][7] && !m_ctrl[p][6] && m_th_last[p] && !m_pins[p][6]) set = 1;
      clr = hl_ack || (cs && we && (addr == 4 || addr == 5) && !din[7]);
      if (set) m_hl = 1'b1;
      else if (clr) m_hl = 1'b0;
    end
    if (cs && we) begin
      if (addr >= 1 && addr <= 3) m_data[addr] = din;
      else if (addr >= 4 && addr <= 6) m_ctrl[addr - 3] = din;
      else if (addr >= 7) begin
        n = (addr - 7) / 3 + 1;
        kind = (addr - 7) % 3;
        if (kind == 0) m_tx[n] = din;
        else if (kind == 2) m_sc[n] = din & 8'hF8;
      end
    end
    m_th_last[1] = m_pins[1][6];
    m_th_last[2] = m_pins[2][6];
    m_pins[1] = p1o;
    m_pins[2] = p2o;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk8("dout", dout, m_dout);
    chk8("hl", {7'b0, hl}, {7'b0, m_hl});
    chk8("port1_in", {1'b0, p1i}, {1'b0, m_data[1][6:0]});
    chk8("port2_in", {1'b0, p2i}, {1'b0, m_data[2][6:0]});
    chk8("port1_dir", {1'b0, p1d}, {1'b0, m_ctrl[1][6:0]});
    chk8("port2_dir", {1'b0, p2d}, {1'b0, m_ctrl[2][6:0]});
  endtask

  // One clock with the given strobe; outputs are checked 1 time unit after the edge.
  task automatic cyc(input logic c, input logic w, input logic [3:0] a, input logic [7:0] d);
    cs = c; we = w; addr = a; din = d;
    @(posedge clk);
    m_step();
    #1;
    check_all();
    cs = 1'b0; we = 1'b0; hl_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; cs = 0; we = 0; addr = 0; din = 0; hl_ack = 0;
    x_export = 1'b1; pal = 1'b0; ndisk = 1'b1; p1o = 7'h7F; p2o = 7'h7F;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all();
    chk8("rst_dout", dout, 8'h00);
    chk8("rst_p1in", {1'b0, p1i}, 8'h7F);

    // Reads straight after reset
    cyc(1, 0, 4'd1, 8'h00);  chk8("rd_data1", dout, 8'h7F);
    cyc(1, 0, 4'd0, 8'h00);  chk8("rd_version", dout, 8'hA0);
    idle(2);                 chk8("dout_hold", dout, 8'hA0);

    // Pin direction/data and mixed read-back
    p1o = 7'h3F;
    cyc(1, 1, 4'd4, 8'h40);
    cyc(1, 1, 4'd1, 8'h00);
    chk8("p1_dir", {1'b0, p1d}, 8'h40);
    chk8("p1_in", {1'b0, p1i}, 8'h00);
    cyc(1, 0, 4'd1, 8'h00);  chk8("rd_data1_mix", dout, 8'h3F);
    cyc(1, 0, 4'd3, 8'h00);  chk8("rd_data3", dout, 8'h7F);

    // Serial registers
    cyc(1, 1, 4'd7, 8'h5A);
    cyc(1, 1, 4'd9, 8'hFF);
    cyc(1, 1, 4'd8, 8'h12);
    cyc(1, 0, 4'd7, 8'h00);  chk8("rd_tx1", dout, 8'h5A);
    cyc(1, 0, 4'd9, 8'h00);  chk8("rd_sctrl1", dout, 8'hF8);
    cyc(1, 0, 4'd8, 8'h00);  chk8("rd_rx1", dout, 8'h00);

    // TH interrupt on port 2, then ack
    cyc(1, 1, 4'd5, 8'h80);
    idle(2);
    p2o = 7'h3F;
    idle(2);                 chk8("hl_set", {7'b0, hl}, {7'b0, TH});
    hl_ack = 1'b1; cyc(0, 0, 4'd0, 8'h00);
    chk8("hl_ack_clr", {7'b0, hl}, 8'h00);

    // Edge coincident with ack: set wins
    p2o = 7'h7F; idle(2);
    p2o = 7'h3F; idle(2);    chk8("hl_pend", {7'b0, hl}, {7'b0, TH});
    p2o = 7'h7F; idle(2);
    p2o = 7'h3F; idle(1);
    hl_ack = 1'b1; cyc(0, 0, 4'd0, 8'h00);
    chk8("hl_set_wins", {7'b0, hl}, {7'b0, TH});
    cyc(1, 1, 4'd5, 8'h00);  chk8("hl_ctrl_clr", {7'b0, hl}, 8'h00);

    // Edge while disarmed is not latched
    p2o = 7'h7F; idle(2);
    p2o = 7'h3F; idle(2);
    cyc(1, 1, 4'd5, 8'h80); idle(2);
    chk8("hl_disarmed", {7'b0, hl}, 8'h00);

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) p1o = 7'($urandom);
      if ($urandom_range(3) == 0) p2o = 7'($urandom);
      if ($urandom_range(15) == 0) begin
        x_export = 1'($urandom); pal = 1'($urandom); ndisk = 1'($urandom);
      end
      hl_ack = ($urandom_range(7) == 0);
      cyc(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
    end

    // Reset in the middle of a write strobe
    p1o = 7'h7F;
    cyc(1, 1, 4'd4, 8'h80);
    idle(2);
    p1o = 7'h3F; idle(2);
    chk8("hl_before_rst", {7'b0, hl}, {7'b0, TH});
    cs = 1'b1; we = 1'b1; addr = 4'd1; din = 8'h00;
    #2 reset = 1'b1;
    @(posedge clk);
    #1 cs = 1'b0; we = 1'b0;
    p1o = 7'h7F;
    reset = 1'b0;
    m_reset();
    check_all();
    chk8("rst_hl", {7'b0, hl}, 8'h00);
    chk8("rst_dout2", dout, 8'h00);
    cyc(1, 0, 4'd1, 8'h00);  chk8("rd_data1_after_rst", dout, 8'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
